uncached_write_buffer: RTL and testbench
========================================

UNCACHED_WRITE_BUFFER -- requirements
Module: uncached_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data_req  in  1  CPU data request valid.
REQ-005 SHALL have port data_wr  in  1  CPU request is a store.
REQ-006 SHALL have port data_wstrb  in  4  CPU byte strobes.
REQ-007 SHALL have port data_addr  in  32  CPU physical address.
REQ-008 SHALL have port data_size  in  3  CPU access size.
REQ-009 SHALL have port data_wdata  in  32  CPU store data.
REQ-010 SHALL have port data_addr_ok  out  1  CPU request accepted this cycle.
REQ-011 SHALL have port data_data_ok  out  1  CPU response valid (store done / load data).
REQ-012 SHALL have port data_rdata  out  32  CPU load data.
REQ-013 SHALL have port mem_req  out  1  memory request valid.
REQ-014 SHALL have port mem_wr  out  1  memory request is a store.
REQ-015 SHALL have port mem_wstrb  out  4  memory byte strobes.
REQ-016 SHALL have port mem_addr  out  32  memory address.
REQ-017 SHALL have port mem_size  out  3  memory access size.
REQ-018 SHALL have port mem_wdata  out  32  memory store data.
REQ-019 SHALL have port mem_addr_ok  in  1  memory accepted request.
REQ-020 SHALL have port mem_data_ok  in  1  memory completed request.
REQ-021 SHALL have port mem_rdata  in  32  memory load data.

Function
REQ-022 SHALL hold a DEPTH-entry FIFO of {addr, size, wstrb, wdata}; count width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-023 SHALL use FSM states IDLE, ST_WAIT, LD_WAIT; at most one memory transaction outstanding.
REQ-024 Store accept: data_addr_ok=1 when data_req && data_wr && count<DEPTH (pre-pop count) && state!=LD_WAIT; entry pushed same edge.
REQ-025 Store response: data_data_ok=1 exactly one cycle after each store acceptance, registered; data_rdata don't-care.
REQ-026 Drain: in IDLE with count>0, mem_req=1 driving head entry, mem_wr=1; on mem_addr_ok go ST_WAIT; in ST_WAIT on mem_data_ok pop head, go IDLE.
REQ-027 Load pass-through: in IDLE with count==0 and no store response pending, a load request drives mem_req=1, mem_wr=0 with CPU fields; data_addr_ok=mem_addr_ok; on accept go LD_WAIT.
REQ-028 In LD_WAIT, data_data_ok=mem_data_ok, data_rdata=mem_rdata combinationally; on mem_data_ok go IDLE.
REQ-029 Loads SHALL NOT bypass buffered stores; memory sees stores in program order before any later load.
REQ-030 Simultaneous push and pop SHALL leave count unchanged; push at full is refused even if pop occurs same cycle.
REQ-031 mem_req fields SHALL stay stable while mem_req=1 and mem_addr_ok=0.
REQ-032 data_data_ok pulses SHALL be in CPU request order and never overlap.

Reset
REQ-033 On resetn=0 asynchronously: FSM=IDLE, count=0, pointers=0, data_addr_ok=0, data_data_ok=0, mem_req=0, mem_wr=0, other outputs 0; outstanding memory transaction abandoned.
REQ-034 Reset mid-drain SHALL discard all buffered stores without further mem_req.

Structure
REQ-035 FSM state encodings and FIFO entry field widths SHALL live in the shared header with the existing core defines.
REQ-036 FIFO storage SHALL be one sub-module, wb_fifo (push/pop/full/empty/head).

Verification
REQ-037 Four stores back-to-back, mem_addr_ok=mem_data_ok=1 -> four data_data_ok, each one cycle after its data_addr_ok; memory sees addresses in order.
REQ-038 Five stores, memory stalled (mem_addr_ok=0) -> first four accepted, fifth data_addr_ok=0 until first pop.
REQ-039 Store to 0x1FAF0000 then load from 0x1FAF0000 -> load mem_req only after store mem_data_ok; data_rdata=mem_rdata=0x12345678.
REQ-040 Buffer full, pop and new store request same cycle -> store refused that cycle, accepted next; count stays 4.
REQ-041 resetn low while in ST_WAIT with 3 entries -> all outputs 0 immediately, count=0, no mem_req after release until new request.

Source files
------------

// File: rtl/uncached_write_buffer_pkg.sv
// Shared definitions for the uncached write buffer.
// Holds the control FSM state encoding, the CPU/memory bus field widths and
// the packed layout of one buffered store entry.
package uncached_write_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int SIZE_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        LD_WAIT = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/uncached_write_buffer_wb_fifo.sv
// wb_fifo: DEPTH-entry store FIFO for the uncached write buffer.
// Ports:
//   clk, resetn   - clock, asynchronous active-low reset
//   push          - write push_entry at the tail (ignored when full)
//   push_entry    - entry to enqueue
//   pop           - drop the head entry (ignored when empty)
//   head          - current head entry, valid when !empty
//   full, empty   - occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module wb_fifo
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign head    = entries[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // simultaneous push and pop leaves the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (do_push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/uncached_write_buffer.sv
// uncached_write_buffer: posts CPU stores into a small FIFO and drains them
// to memory one at a time; loads pass straight through once every earlier
// store has completed at memory.
// Ports:
//   clk, resetn                       - clock, asynchronous active-low reset
//   data_req/wr/wstrb/addr/size/wdata - CPU request channel
//   data_addr_ok, data_data_ok        - CPU accept / response strobes
//   data_rdata                        - CPU load data
//   mem_req/wr/wstrb/addr/size/wdata  - memory request channel
//   mem_addr_ok, mem_data_ok          - memory accept / completion strobes
//   mem_rdata                         - memory load data
//
// state   | meaning
// IDLE    | no memory transaction outstanding; drain head store or issue load
// ST_WAIT | buffered store accepted by memory, waiting for completion
// LD_WAIT | load accepted by memory, forwarding its response to the CPU
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    wb_state_e state;
    wb_state_e state_nxt;
    logic      st_resp;
    logic      push;
    logic      pop;
    logic      fifo_full;
    logic      fifo_empty;
    logic      load_go;
    wb_entry_t head;
    wb_entry_t push_entry;

    assign push_entry = '{addr: data_addr, size: data_size, wstrb: data_wstrb, wdata: data_wdata};

    // The full test uses the occupancy before any pop this cycle, so a store
    // arriving while full waits one more cycle even if the head retires now.
    assign push = data_req && data_wr && !fifo_full && (state != LD_WAIT);

    // A load may only go out once the FIFO is empty and the last store's
    // response has been given, so memory and the CPU both see program order.
    assign load_go = (state == IDLE) && fifo_empty && !st_resp && data_req && !data_wr;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            st_resp <= 1'b0;
        end else begin
            state   <= state_nxt;
            st_resp <= push;
        end
    end

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wstrb    = '0;
        mem_addr     = '0;
        mem_size     = '0;
        mem_wdata    = '0;
        data_addr_ok = push;
        data_data_ok = st_resp;
        data_rdata   = '0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    // head is only popped in ST_WAIT, so these fields hold
                    // steady for as long as memory stalls the request
                    mem_req   = 1'b1;
                    mem_wr    = 1'b1;
                    mem_wstrb = head.wstrb;
                    mem_addr  = head.addr;
                    mem_size  = head.size;
                    mem_wdata = head.wdata;
                    if (mem_addr_ok) state_nxt = ST_WAIT;
                end else if (load_go) begin
                    mem_req      = 1'b1;
                    mem_wr       = 1'b0;
                    mem_wstrb    = data_wstrb;
                    mem_addr     = data_addr;
                    mem_size     = data_size;
                    mem_wdata    = data_wdata;
                    data_addr_ok = mem_addr_ok;
                    if (mem_addr_ok) state_nxt = LD_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_data_ok) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LD_WAIT: begin
                // no store can be accepted or pending here, so the load
                // response owns data_data_ok
                data_data_ok = mem_data_ok;
                data_rdata   = mem_rdata;
                if (mem_data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uncached_write_buffer.sv
`timescale 1ns/1ps
module tb_uncached_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [2:0]  data_size = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [2:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    uncached_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_size     (mem_size),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_txn_t;

    mem_txn_t exp_q[$];
    mem_txn_t mon_q[$];
    int       acc_q[$];
    int       lacc_q[$];
    int       dok_q[$];

    int cyc = 0;
    int mreq_cnt = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn) begin
            if (data_req && data_wr && data_addr_ok)  acc_q.push_back(cyc);
            if (data_req && !data_wr && data_addr_ok) lacc_q.push_back(cyc);
            if (data_data_ok) dok_q.push_back(cyc);
            if (mem_req) mreq_cnt <= mreq_cnt + 1;
            if (mem_req && mem_addr_ok)
                mon_q.push_back('{wr: mem_wr, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_queues;
        exp_q.delete();
        mon_q.delete();
        acc_q.delete();
        lacc_q.delete();
        dok_q.delete();
    endtask

    // Holds a CPU request until it is accepted or the budget runs out.
    task automatic cpu_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int budget, output bit ok);
        data_req   = 1'b1;
        data_wr    = wr;
        data_addr  = addr;
        data_wdata = wdata;
        data_wstrb = 4'hF;
        data_size  = 3'd2;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (data_addr_ok) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        data_req = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        step(3);
        @(negedge clk);
        n_cmp++;
        if ({data_addr_ok, data_data_ok, mem_req, mem_wr} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {data_addr_ok, data_data_ok, mem_req, mem_wr});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_wstrb, mem_size, data_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: addr %h wdata %h strb %h size %h rdata %h, want all 0",
                     mem_addr, mem_wdata, mem_wstrb, mem_size, data_rdata);
        end
        n_cmp++;
        if (dut.u_fifo.cnt !== 0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d want 0", dut.u_fifo.cnt);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        step(2);
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset mem_req: got %b want 0", mem_req);
        end
        step(1);
    endtask

    task automatic test_back_to_back;
        bit          ok;
        logic [31:0] a;
        logic [31:0] d;
        mem_txn_t    e;
        mem_txn_t    m;
        clear_queues();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 32'h1000_0000 + 32'(i * 4);
            d = 32'hA5A5_0000 + 32'(i);
            exp_q.push_back('{wr: 1'b1, addr: a, wdata: d, wstrb: 4'hF});
            cpu_req(1'b1, a, d, 10, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL b2b_accept[%0d]: not accepted within 10 cycles, want accepted", i);
            end
        end
        for (int i = 0; i < 40 && mon_q.size() < 4; i++) step(1);
        step(2);
        n_cmp++;
        if (mon_q.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_mem_count: got %0d want 4", mon_q.size());
        end
        while (exp_q.size() > 0 && mon_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mon_q.pop_front();
            n_cmp++;
            if (m !== e) begin
                n_bad++;
                $display("FAIL b2b_mem_txn: got wr %b addr %h data %h strb %h want wr %b addr %h data %h strb %h",
                         m.wr, m.addr, m.wdata, m.wstrb, e.wr, e.addr, e.wdata, e.wstrb);
            end
        end
        n_cmp++;
        if (acc_q.size() != 4 || dok_q.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_resp_count: got acc %0d ok %0d want 4 4", acc_q.size(), dok_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (dok_q[i] !== acc_q[i] + 1) begin
                    n_bad++;
                    $display("FAIL b2b_resp_latency[%0d]: got cycle %0d want %0d", i, dok_q[i], acc_q[i] + 1);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (acc_q[i] !== acc_q[i-1] + 1) begin
                    n_bad++;
                    $display("FAIL b2b_accept_gap[%0d]: got cycle %0d want %0d", i, acc_q[i], acc_q[i-1] + 1);
                end
            end
        end
    endtask

    task automatic test_full_stall;
        bit          ok;
        bit          refused;
        bit          stable;
        int          c;
        int          got;
        logic [31:0] a;
        mem_txn_t    e;
        mem_txn_t    m;
        clear_queues();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h2000_0000 + 32'(i * 4);
            exp_q.push_back('{wr: 1'b1, addr: a, wdata: 32'h5500_0000 + 32'(i), wstrb: 4'hF});
            cpu_req(1'b1, a, 32'h5500_0000 + 32'(i), 10, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL full_accept[%0d]: not accepted, want accepted", i);
            end
        end
        exp_q.push_back('{wr: 1'b1, addr: 32'h2000_0010, wdata: 32'h5500_0004, wstrb: 4'hF});
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_addr  = 32'h2000_0010;
        data_wdata = 32'h5500_0004;
        refused = 1'b1;
        stable  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (data_addr_ok) refused = 1'b0;
            if (!mem_req || mem_addr !== 32'h2000_0000 || mem_wdata !== 32'h5500_0000) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!refused) begin
            n_bad++;
            $display("FAIL full_refuse: got data_addr_ok 1 while full, want 0");
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL stall_stable: got head fields changing or mem_req dropped, want addr 20000000 held");
        end
        n_cmp++;
        if (dut.u_fifo.cnt !== 4) begin
            n_bad++;
            $display("FAIL full_count: got %0d want 4", dut.u_fifo.cnt);
        end
        c = cyc;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        got = -1;
        for (int i = 0; i < 10 && got < 0; i++) begin
            @(negedge clk);
            if (data_addr_ok) got = cyc;
            @(posedge clk);
            #1;
        end
        data_req = 1'b0;
        n_cmp++;
        if (got !== c + 2) begin
            n_bad++;
            $display("FAIL fifth_accept_cycle: got %0d want %0d", got, c + 2);
        end
        n_cmp++;
        if (dut.u_fifo.cnt !== 4) begin
            n_bad++;
            $display("FAIL count_after_swap: got %0d want 4", dut.u_fifo.cnt);
        end
        for (int i = 0; i < 60 && mon_q.size() < 5; i++) step(1);
        step(2);
        n_cmp++;
        if (mon_q.size() != 5) begin
            n_bad++;
            $display("FAIL full_mem_count: got %0d want 5", mon_q.size());
        end
        while (exp_q.size() > 0 && mon_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mon_q.pop_front();
            n_cmp++;
            if (m !== e) begin
                n_bad++;
                $display("FAIL full_mem_txn: got addr %h data %h want addr %h data %h",
                         m.addr, m.wdata, e.addr, e.wdata);
            end
        end
    endtask

    task automatic test_store_then_load;
        bit          ok;
        bit          got;
        logic [31:0] rd;
        mem_txn_t    e;
        mem_txn_t    m;
        clear_queues();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1234_5678;
        exp_q.push_back('{wr: 1'b1, addr: 32'h1FAF_0000, wdata: 32'hCAFE_F00D, wstrb: 4'hF});
        exp_q.push_back('{wr: 1'b0, addr: 32'h1FAF_0000, wdata: 32'h0, wstrb: 4'hF});
        cpu_req(1'b1, 32'h1FAF_0000, 32'hCAFE_F00D, 10, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL sl_store_accept: not accepted, want accepted");
        end
        cpu_req(1'b0, 32'h1FAF_0000, 32'h0, 20, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL sl_load_accept: not accepted within 20 cycles, want accepted");
        end
        got = 1'b0;
        rd  = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (data_data_ok) begin
                got = 1'b1;
                rd  = data_rdata;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!got || rd !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL sl_load_data: got ok %b rdata %h want ok 1 rdata 12345678", got, rd);
        end
        n_cmp++;
        if (acc_q.size() != 1 || lacc_q.size() != 1 || lacc_q[0] !== acc_q[0] + 3) begin
            n_bad++;
            $display("FAIL sl_load_issue_cycle: got store %0d load %0d want load = store + 3",
                     acc_q.size() > 0 ? acc_q[0] : -1, lacc_q.size() > 0 ? lacc_q[0] : -1);
        end
        n_cmp++;
        if (mon_q.size() != 2) begin
            n_bad++;
            $display("FAIL sl_mem_count: got %0d want 2", mon_q.size());
        end else begin
            e = exp_q.pop_front();
            m = mon_q.pop_front();
            n_cmp++;
            if (m !== e) begin
                n_bad++;
                $display("FAIL sl_first_is_store: got wr %b addr %h data %h want wr 1 addr %h data %h",
                         m.wr, m.addr, m.wdata, e.addr, e.wdata);
            end
            e = exp_q.pop_front();
            m = mon_q.pop_front();
            n_cmp++;
            if (m.wr !== e.wr || m.addr !== e.addr) begin
                n_bad++;
                $display("FAIL sl_second_is_load: got wr %b addr %h want wr 0 addr %h", m.wr, m.addr, e.addr);
            end
        end
        n_cmp++;
        if (dok_q.size() != 2) begin
            n_bad++;
            $display("FAIL sl_resp_count: got %0d want 2", dok_q.size());
        end
    endtask

    task automatic test_reset_mid_drain;
        bit       ok;
        int       base;
        mem_txn_t e;
        mem_txn_t m;
        clear_queues();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_req(1'b1, 32'h3000_0000 + 32'(i * 4), 32'h7700_0000 + 32'(i), 10, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rst_store_accept[%0d]: not accepted, want accepted", i);
            end
        end
        step(2);
        n_cmp++;
        if (dut.state !== uncached_write_buffer_pkg::ST_WAIT || dut.u_fifo.cnt !== 3) begin
            n_bad++;
            $display("FAIL rst_pre_state: got state %0d count %0d want state 1 count 3",
                     dut.state, dut.u_fifo.cnt);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({data_addr_ok, data_data_ok, mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, mem_size, data_rdata} !== '0) begin
            n_bad++;
            $display("FAIL rst_outputs: got req %b wr %b addr %h data %h ok %b%b want all 0",
                     mem_req, mem_wr, mem_addr, mem_wdata, data_addr_ok, data_data_ok);
        end
        n_cmp++;
        if (dut.u_fifo.cnt !== 0) begin
            n_bad++;
            $display("FAIL rst_count: got %0d want 0", dut.u_fifo.cnt);
        end
        step(2);
        resetn = 1'b1;
        mem_data_ok = 1'b1;
        clear_queues();
        base = mreq_cnt;
        step(10);
        n_cmp++;
        if (mreq_cnt - base != 0) begin
            n_bad++;
            $display("FAIL rst_no_mem_req: got %0d request cycles want 0", mreq_cnt - base);
        end
        exp_q.push_back('{wr: 1'b1, addr: 32'h3000_0100, wdata: 32'h0BAD_BEEF, wstrb: 4'hF});
        cpu_req(1'b1, 32'h3000_0100, 32'h0BAD_BEEF, 10, ok);
        for (int i = 0; i < 20 && mon_q.size() < 1; i++) step(1);
        n_cmp++;
        if (mon_q.size() != 1) begin
            n_bad++;
            $display("FAIL rst_new_store_count: got %0d want 1", mon_q.size());
        end else begin
            e = exp_q.pop_front();
            m = mon_q.pop_front();
            n_cmp++;
            if (m !== e) begin
                n_bad++;
                $display("FAIL rst_new_store: got addr %h data %h want addr %h data %h",
                         m.addr, m.wdata, e.addr, e.wdata);
            end
        end
        step(3);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_store_then_load();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
